// File: rtl/valu_issuer.sv
// Command-side driver for vector_alu: issues lane ops over valid/ready, captures the
// registered Z one cycle later and returns tagged, flagged results through an in-order FIFO.
module valu_issuer #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [N-1:0][WIDTH-1:0]      cmd_a,
  input  logic [N-1:0][WIDTH-1:0]      cmd_b,
  input  logic [N-1:0][2:0]            cmd_sel,
  input  logic [N-1:0]                 cmd_mask,
  input  logic [TAGW-1:0]              cmd_tag,
  output logic [N-1:0][WIDTH-1:0]      alu_a,
  output logic [N-1:0][WIDTH-1:0]      alu_b,
  output logic [N-1:0][2:0]            alu_sel,
  output logic [N-1:0]                 alu_enable,
  input  logic [N-1:0][2*WIDTH-1:0]    alu_z,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [N-1:0][2*WIDTH-1:0]    res_z,
  output logic [TAGW-1:0]              res_tag,
  output logic [N-1:0]                 res_dz,
  output logic [N-1:0]                 res_ill,
  output logic                         busy
);

  localparam int ZW = 2 * WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

  logic                  fire;
  logic                  pop;
  logic                  inflight;
  logic [TAGW-1:0]       if_tag;
  logic [N-1:0]          if_mask;
  logic [N-1:0]          if_dz;
  logic [N-1:0]          if_ill;
  logic [N-1:0]          cmd_dz;
  logic [N-1:0]          cmd_ill;
  logic [N-1:0][ZW-1:0]  cap_z;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW:0]           occupancy;

  logic [N-1:0][ZW-1:0]  z_mem   [DEPTH];
  logic [TAGW-1:0]       tag_mem [DEPTH];
  logic [N-1:0]          dz_mem  [DEPTH];
  logic [N-1:0]          ill_mem [DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit: the op in flight already owns a FIFO slot, so a push can never be refused.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign cmd_ready  = !arst && (occupancy < DEPTH_C);
  assign fire       = cmd_valid && cmd_ready;

  assign alu_a      = cmd_a;
  assign alu_b      = cmd_b;
  assign alu_sel    = cmd_sel;
  assign alu_enable = fire ? cmd_mask : '0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cmd_dz  = '0;
    cmd_ill = '0;
    cap_z   = '0;
    for (int i = 0; i < N; i++) begin
      cmd_dz[i]  = cmd_mask[i] && (cmd_sel[i] == 3'b101) && (cmd_b[i] == '0);
      cmd_ill[i] = cmd_mask[i] && (cmd_sel[i][2:1] == 2'b11);
      cap_z[i]   = if_mask[i] ? alu_z[i] : '0;
    end
  end

  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign res_z     = res_valid ? z_mem[rd_ptr]   : '0;
  assign res_tag   = res_valid ? tag_mem[rd_ptr] : '0;
  assign res_dz    = res_valid ? dz_mem[rd_ptr]  : '0;
  assign res_ill   = res_valid ? ill_mem[rd_ptr] : '0;
  assign busy      = inflight || res_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (arst) begin
      inflight <= 1'b0;
      if_tag   <= '0;
      if_mask  <= '0;
      if_dz    <= '0;
      if_ill   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= fire;
      if (fire) begin
        if_tag  <= cmd_tag;
        if_mask <= cmd_mask;
        if_dz   <= cmd_dz;
        if_ill  <= cmd_ill;
      end
      if (inflight) wr_ptr <= next_ptr(wr_ptr);
      if (pop)      rd_ptr <= next_ptr(rd_ptr);
      if (inflight && !pop)      count <= count + CW'(1);
      else if (!inflight && pop) count <= count - CW'(1);
    end
  end

  // NOTE: storage is not reset; outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (inflight) begin
      z_mem[wr_ptr]   <= cap_z;
      tag_mem[wr_ptr] <= if_tag;
      dz_mem[wr_ptr]  <= if_dz;
      ill_mem[wr_ptr] <= if_ill;
    end
  end

endmodule

// File: tb/tb_valu_issuer.sv
// Self-checking bench for valu_issuer with a behavioural vector_alu stand-in and a
// scoreboard of expected results keyed by issue order.
module tb_valu_issuer;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 4;
  localparam int T = 4;

  typedef logic [N-1:0][W-1:0] opv_t;
  typedef logic [N-1:0][2:0]   selv_t;

  typedef struct {
    logic [63:0]  z;
    logic [T-1:0] tag;
    logic [N-1:0] dz;
    logic [N-1:0] ill;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   arst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  opv_t                   cmd_a, cmd_b, alu_a, alu_b;
  selv_t                  cmd_sel, alu_sel;
  logic [N-1:0]           cmd_mask, alu_enable;
  logic [T-1:0]           cmd_tag, res_tag;
  logic [N-1:0][2*W-1:0]  alu_z, res_z;
  logic                   res_valid, res_ready, busy;
  logic [N-1:0]           res_dz, res_ill;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q[$];
  int   run = 0;
  int   max_run = 0;

  always #5 clk = ~clk;

  valu_issuer #(.N(N), .WIDTH(W), .DEPTH(D), .TAGW(T)) dut (
    .clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_mask(cmd_mask), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_enable(alu_enable), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_tag(res_tag), .res_dz(res_dz), .res_ill(res_ill),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] s);
    case (s)
      3'b000:  return 16'(a) + 16'(b);
      3'b001:  return 16'(a) - 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a | b};
      3'b100:  return 16'(a) * 16'(b);
      3'b101:  return (b == 8'd0) ? 16'h0000 : 16'(a / b);
      default: return 16'h0000;
    endcase
  endfunction

  // vector_alu stand-in: registered Z; disabled lanes show junk the issuer must mask.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (arst) alu_z[i] <= '0;
      else      alu_z[i] <= alu_enable[i] ? ref_fn(alu_a[i], alu_b[i], alu_sel[i]) : 16'hBEEF;
    end
  end

  // Monitor: scoreboard push on fire, pop/compare on result handshake, stability while stalled.
  logic         hold = 1'b0;
  logic [63:0]  hold_z;
  logic [T-1:0] hold_tag;
  always @(negedge clk) begin
    if (arst) begin
      q.delete();
      hold = 1'b0;
      run  = 0;
    end else begin
      exp_t e;
      if (hold) begin
        check("hold_z", res_z, hold_z);
        check("hold_tag", 64'(res_tag), 64'(hold_tag));
      end
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 64'(res_tag), 64'hFFFF);
        end else begin
          e = q.pop_front();
          check("res_z", res_z, e.z);
          check("res_tag", 64'(res_tag), 64'(e.tag));
          check("res_dz", 64'(res_dz), 64'(e.dz));
          check("res_ill", 64'(res_ill), 64'(e.ill));
        end
      end
      check("alu_enable", 64'(alu_enable), (cmd_valid && cmd_ready) ? 64'(cmd_mask) : 64'd0);
      if (cmd_valid && cmd_ready) begin
        e.z   = '0;
        e.dz  = '0;
        e.ill = '0;
        e.tag = cmd_tag;
        for (int i = 0; i < N; i++) begin
          if (cmd_mask[i]) begin
            e.z[16*i +: 16] = ref_fn(cmd_a[i], cmd_b[i], cmd_sel[i]);
            e.dz[i]  = (cmd_sel[i] == 3'b101) && (cmd_b[i] == 8'd0);
            e.ill[i] = (cmd_sel[i] == 3'b110) || (cmd_sel[i] == 3'b111);
          end
        end
        q.push_back(e);
      end
      run = res_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      hold     = res_valid && !res_ready;
      hold_z   = res_z;
      hold_tag = res_tag;
    end
  end

  task automatic send(input opv_t a, input opv_t b, input selv_t s, input logic [N-1:0] m,
                      input logic [T-1:0] tag, output int waits);
    logic f;
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_mask = m; cmd_tag = tag;
    cmd_valid = 1'b1;
    waits = 0;
    f = 1'b0;
    while (!f) begin
      @(negedge clk);
      f = cmd_ready;
      @(posedge clk);
      #1;
      if (!f) begin
        waits++;
        if (waits > 200) begin
          check("send_timeout", 64'(tag), 64'hFFFF);
          f = 1'b1;
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic lat_check(input string tag, input logic [63:0] z, input logic [T-1:0] t,
                           input logic [N-1:0] dz, input logic [N-1:0] ill);
    @(negedge clk);
    check({tag, "_t1_valid"}, 64'(res_valid), 64'd0);
    @(negedge clk);
    check({tag, "_t2_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_z"}, res_z, z);
    check({tag, "_tag"}, 64'(res_tag), 64'(t));
    check({tag, "_dz"}, 64'(res_dz), 64'(dz));
    check({tag, "_ill"}, 64'(res_ill), 64'(ill));
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((q.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain_q"}, 64'(q.size()), 64'd0);
    check({tag, "_drain_busy"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, stalls;
    arst = 1'b1; res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_mask = 4'b1111; cmd_tag = '0;

    // Reset held with a command offered: nothing issues.
    repeat (2) begin
      @(negedge clk);
      check("rst_alu_enable", 64'(alu_enable), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    arst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_z", res_z, 64'd0);
    check("post_rst_tag", 64'(res_tag), 64'd0);
    check("post_rst_flags", 64'({res_dz, res_ill}), 64'd0);
    @(posedge clk); #1;

    // Single lane add, latency two cycles.
    send({8'd7, 8'd7, 8'd7, 8'd200}, {8'd3, 8'd3, 8'd3, 8'd100}, '0, 4'b0001, 4'd5, w);
    lat_check("add", {16'd0, 16'd0, 16'd0, 16'd300}, 4'd5, 4'b0000, 4'b0000);
    drain("add");

    // Divide-by-zero and illegal opcode flags.
    send({8'd1, 8'd9, 8'd4, 8'd4}, {8'd1, 8'd0, 8'd2, 8'd2},
         {3'b110, 3'b101, 3'b000, 3'b000}, 4'b1100, 4'd3, w);
    lat_check("flags", 64'd0, 4'd3, 4'b0100, 4'b1000);
    drain("flags");

    // Zero mask still returns its tag with all-zero results.
    send({8'd50, 8'd60, 8'd70, 8'd80}, {8'd1, 8'd2, 8'd3, 8'd4}, '0, 4'b0000, 4'd9, w);
    lat_check("zero_mask", 64'd0, 4'd9, 4'b0000, 4'b0000);
    drain("zero_mask");

    // Backpressure: exactly DEPTH commands accepted, then order on release.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send({8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)}, {8'd2, 8'd3, 8'd4, 8'd5},
           {3'b000, 3'b001, 3'b011, 3'b100}, 4'b1111, 4'(i), w);
      check("fill_waits", 64'(w), 64'd0);
    end
    cmd_valid = 1'b1; cmd_tag = 4'd4;
    repeat (3) begin
      @(negedge clk);
      check("full_ready", 64'(cmd_ready), 64'd0);
    end
    check("full_accepted", 64'(q.size()), 64'd4);
    @(posedge clk); #1;
    cmd_valid = 1'b0; res_ready = 1'b1;
    for (int i = 4; i < 8; i++)
      send({8'(3 * i), 8'd0, 8'd255, 8'(i)}, {8'd3, 8'd0, 8'd255, 8'd1},
           {3'b101, 3'b101, 3'b100, 3'b010}, 4'b1111, 4'(i), w);
    drain("bp");

    // Back-to-back issue at full throughput.
    max_run = 0;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      send({8'd1, 8'd1, 8'd15, 8'd1}, {8'd1, 8'd1, 8'd15, 8'd1},
           {3'b000, 3'b000, 3'b100, 3'b000}, 4'b0010, 4'(i + 8), w);
      stalls += w;
    end
    check("b2b_stalls", 64'(stalls), 64'd0);
    drain("b2b");
    check("b2b_run", 64'(max_run), 64'd8);

    // Reset during capture discards everything in flight or queued.
    res_ready = 1'b0;
    send({8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, '0, 4'b1111, 4'd1, w);
    send({8'd2, 8'd2, 8'd2, 8'd2}, {8'd2, 8'd2, 8'd2, 8'd2}, '0, 4'b1111, 4'd2, w);
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0; res_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_valid", 64'(res_valid), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    send({8'd0, 8'd0, 8'd12, 8'd0}, {8'd0, 8'd0, 8'd5, 8'd0}, {3'b000, 3'b000, 3'b001, 3'b000},
         4'b0010, 4'd6, w);
    lat_check("after_rst", {16'd0, 16'd0, 16'd7, 16'd0}, 4'd6, 4'b0000, 4'b0000);
    drain("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
